// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver: FSM states, internal signal bundle,
// frame constants and the 2-of-3 vote used by the optional majority sampler.
package pkg_uart;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_STOP_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } e_uart_rx_state;

    typedef struct packed {
        logic load;
        logic en;
        logic tick;
        logic sample;
    } st_uart_rx;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/uart_rx_baudgen.sv
// Loadable baud down-counter for the receiver; o_tick marks each mid-bit sample point.
// A half-period load aligns the first tick to the middle of the start bit.
module baudgen_rx #(
    parameter int BAUDRATE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_load,
    input  logic i_half,
    output logic o_tick
);

    localparam int            CW   = $clog2(BAUDRATE);
    localparam logic [CW-1:0] FULL = CW'(BAUDRATE - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);

    logic [CW-1:0] cnt_reg;

    // Terminal count is zero, so a full period reloads BAUDRATE-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (i_load) begin
            cnt_reg <= i_half ? HALF : FULL;
        end else if (i_en) begin
            cnt_reg <= (cnt_reg == '0) ? FULL : cnt_reg - 1'b1;
        end
    end

    assign o_tick = i_en && (cnt_reg == '0);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit, mid-bit sampling.
// Optional build macro UART_RX_MAJORITY_EN votes each sample over the last three rxs values.
module uart_rx
    import pkg_uart::*;
#(
    parameter int BAUDRATE = 50000000 / 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]                sync_reg;
    logic                      rxs;
    logic                      sample_bit;
    logic                      tick;
    e_uart_rx_state            state_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [2:0]                bit_cnt_reg;
    logic                      parity_reg;
    st_uart_rx                 w;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], rx};
        end
    end

    assign rxs = sync_reg[1];

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_reg;

    // Together with rxs this forms the window of the last three synchronised values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], rxs};
        end
    end

    assign sample_bit = maj3({hist_reg, rxs});
`else
    assign sample_bit = rxs;
`endif

    always_comb begin
        w        = '0;
        w.load   = (state_reg == RX_IDLE) && !rxs;
        w.en     = state_reg inside {RX_START, RX_DATA, RX_PARITY, RX_STOP};
        w.tick   = tick;
        w.sample = sample_bit;
    end

    baudgen_rx #(
        .BAUDRATE(BAUDRATE)
    ) u_baudgen (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w.en),
        .i_load(w.load),
        .i_half(1'b1),
        .o_tick(tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= RX_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            parity_reg  <= 1'b0;
            data        <= '0;
            valid       <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (!rxs) begin
                        state_reg <= RX_START;
                        busy      <= 1'b1;
                    end
                end
                RX_START: begin
                    if (w.tick) begin
                        if (w.sample) begin
                            state_reg <= RX_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state_reg   <= RX_DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (w.tick) begin
                        shift_reg   <= {w.sample, shift_reg[UART_DATA_BITS-1:1]};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg <= RX_PARITY;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w.tick) begin
                        parity_reg <= w.sample;
                        state_reg  <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leaving mid stop bit lets a following start edge be caught with no gap.
                    if (w.tick) begin
                        valid      <= 1'b1;
                        data       <= shift_reg;
                        parity_err <= ^{shift_reg, parity_reg};
                        frame_err  <= (w.sample != UART_STOP_LEVEL);
                        if (w.sample == UART_STOP_LEVEL) begin
                            state_reg <= RX_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            state_reg <= RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rxs) begin
                        state_reg <= RX_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= RX_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BAUDRATE=16: frame-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_uart_rx;

    localparam int B  = 16;
    localparam int H  = 8;
    localparam int NC = 4096;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int         c;
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ev_t;

    ev_t ev_q[$];

    bit rxline  [NC];
    bit rstlow  [NC];
    bit rxs_arr [NC];

    // Reference model state
    int         m_mode = 0;   // 0 idle, 1 in frame, 2 waiting for line high
    int         m_d0   = 0;
    bit         armed  = 0;
    logic       e_valid, e_pe, e_fe, e_busy;
    logic [7:0] e_data;

    uart_rx #(
        .BAUDRATE(B)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit samp(input int s);
`ifdef UART_RX_MAJORITY_EN
        int n;
        n = int'(rxs_arr[s-2]) + int'(rxs_arr[s-1]) + int'(rxs_arr[s]);
        return n >= 2;
`else
        return rxs_arr[s];
`endif
    endfunction

    // Monitor: record line, compare outputs, then advance the model one cycle.
    initial begin
        bit         rxs_c;
        logic [7:0] md;
        bit         mpar, mstop;
        forever begin
            @(negedge clk);
            rxline[cyc] = rx;
            rstlow[cyc] = !rst;
            rxs_c = (cyc < 3) ? 1'b1 : ((rstlow[cyc-1] || rstlow[cyc-2]) ? 1'b1 : rxline[cyc-2]);
            rxs_arr[cyc] = rxs_c;

            if (armed) begin
                checks++;
                if ({valid, data, parity_err, frame_err, busy} !== {e_valid, e_data, e_pe, e_fe, e_busy}) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d actual v=%b data=%h pe=%b fe=%b busy=%b required v=%b data=%h pe=%b fe=%b busy=%b",
                             cyc, valid, data, parity_err, frame_err, busy, e_valid, e_data, e_pe, e_fe, e_busy);
                end
                if (valid === 1'b1) ev_q.push_back('{c: cyc, d: data, pe: parity_err, fe: frame_err});
            end

            if (rstlow[cyc]) begin
                m_mode = 0;
                armed  = 1;
                e_valid = 0; e_data = 8'h00; e_pe = 0; e_fe = 0; e_busy = 0;
            end else if (armed) begin
                e_valid = 0;
                case (m_mode)
                    0: if (!rxs_c) begin
                        m_mode = 1;
                        m_d0   = cyc;
                    end
                    1: if (cyc == m_d0 + H && samp(cyc)) begin
                        m_mode = 0;
                    end else if (cyc == m_d0 + H + 10 * B) begin
                        for (int i = 0; i < 8; i++) md[i] = samp(m_d0 + H + (i + 1) * B);
                        mpar    = samp(m_d0 + H + 9 * B);
                        mstop   = samp(m_d0 + H + 10 * B);
                        e_valid = 1;
                        e_data  = md;
                        e_pe    = ^{md, mpar};
                        e_fe    = !mstop;
                        m_mode  = mstop ? 0 : 2;
                    end
                    default: if (rxs_c) m_mode = 0;
                endcase
                e_busy = (m_mode != 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required finish", cyc);
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        step(n);
    endtask

    task automatic at_cycle(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par, input bit stop,
                              input int glitch, input int len, output int t0);
        logic [10:0] bits;
        bits = {stop, par, d, 1'b0};
        t0 = cyc;
        for (int off = 0; off < len; off++) begin
            rx = bits[off / B] ^ (off == glitch);
            step(1);
        end
    endtask

    task automatic expect_event(input string nm, input int t0, input logic [7:0] d,
                                input bit pe, input bit fe);
        ev_t e;
        chk({nm, "_count"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            e = ev_q.pop_front();
            chk({nm, "_cycle"}, e.c, t0 + 2 + H + 10 * B + 1);
            chk({nm, "_data"}, e.d, d);
            chk({nm, "_parity_err"}, e.pe, pe);
            chk({nm, "_frame_err"}, e.fe, fe);
        end
        ev_q.delete();
    endtask

    initial begin
        int t0, t1, r;
        rst = 1'b0;
        rx  = 1'b1;
        step(5);
        rst = 1'b1;
        step(2);
        at_cycle(cyc);
        chk("reset_outputs", {valid, data, parity_err, frame_err, busy}, 12'h000);
        step(1);
        idle(20);

        // Good frame, valid expected at D+169 where D = t0+2
        send_frame(8'hA5, 1'b0, 1'b1, -1, 176, t0);
        idle(20);
        expect_event("good_a5", t0, 8'hA5, 1'b0, 1'b0);
        chk("good_a5_busy_after", busy, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b1, -1, 176, t0);
        idle(20);
        expect_event("parity_a5", t0, 8'hA5, 1'b1, 1'b0);

        // Stop bit low followed by a held-low line
        send_frame(8'h3C, 1'b0, 1'b0, -1, 176, t0);
        step(40);
        at_cycle(cyc);
        chk("break_busy_held", busy, 1'b1);
        step(1);
        idle(30);
        expect_event("break_3c", t0, 8'h3C, 1'b0, 1'b1);
        chk("break_busy_released", busy, 1'b0);

        // Short low pulse: false start
        t0 = cyc;
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        at_cycle(t0 + 2 + H);
        chk("false_start_busy_high", busy, 1'b1);
        at_cycle(t0 + 2 + H + 1);
        chk("false_start_busy_low", busy, 1'b0);
        step(1);
        idle(30);
        chk("false_start_no_valid", ev_q.size(), 0);
        ev_q.delete();

        // Back-to-back frames
        send_frame(8'h00, 1'b0, 1'b1, -1, 176, t0);
        send_frame(8'hFF, 1'b0, 1'b1, -1, 176, t1);
        idle(30);
        chk("b2b_count", ev_q.size(), 2);
        if (ev_q.size() == 2) begin
            chk("b2b_spacing", ev_q[1].c - ev_q[0].c, 176);
            chk("b2b_first_data", ev_q[0].d, 8'h00);
            chk("b2b_second_data", ev_q[1].d, 8'hFF);
            chk("b2b_errors", {ev_q[0].pe, ev_q[0].fe, ev_q[1].pe, ev_q[1].fe}, 4'h0);
        end
        ev_q.delete();

        // Reset after data bit 3 aborts the frame
        send_frame(8'h55, 1'b0, 1'b1, -1, 5 * B, t0);
        r   = cyc;
        rst = 1'b0;
        rx  = 1'b1;
        step(1);
        rst = 1'b1;
        at_cycle(r + 1);
        chk("midframe_reset_outputs", {valid, data, parity_err, frame_err, busy}, 12'h000);
        step(1);
        idle(20);
        chk("midframe_reset_no_valid", ev_q.size(), 0);
        ev_q.delete();
        send_frame(8'h55, 1'b0, 1'b1, -1, 176, t0);
        idle(20);
        expect_event("after_reset_55", t0, 8'h55, 1'b0, 1'b0);

        // One-cycle high glitch landing on the data bit 2 sample point
        send_frame(8'h00, 1'b0, 1'b1, 2 + H + 3 * B - 2, 176, t0);
        idle(20);
`ifdef UART_RX_MAJORITY_EN
        expect_event("glitch_00", t0, 8'h00, 1'b0, 1'b0);
`else
        expect_event("glitch_00", t0, 8'h04, 1'b1, 1'b0);
`endif

        idle(10);
        chk("no_stray_valid", ev_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
